stopwatch_cu: RTL and testbench
===============================

Name: stopwatch_cu

Overview:
- Control unit for the stopwatch datapath. Converts three raw push-button inputs (run/stop, clear, lap) into clean control levels: run_stop, clear and lap_hold.
- Each button passes through a 2-FF synchronizer, a debouncer and a rising-edge detector; the resulting one-cycle pulses drive a Moore FSM.
- Sits between the board button pins and the datapath's run_stop/clear inputs. lap_hold goes to the display mux.

Parameters:
- DEB_CYCLES, 1_000_000, consecutive clocks a synchronized button level must differ from the debounced level before it is accepted (10 ms at 100 MHz); legal range >= 1.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- btn_run  input  1  raw run/stop button, asynchronous, active-high
- btn_clear  input  1  raw clear button, asynchronous, active-high
- btn_lap  input  1  raw lap button, asynchronous, active-high
- run_stop  output  1  level; 1 = datapath counting
- clear  output  1  one-cycle pulse; clears datapath counters
- lap_hold  output  1  level; 1 = display frozen at captured time

Behaviour:
- All state updates on posedge clk. rst is sampled synchronously. Reset values:
  - All sync flops, debounced levels and delayed levels = 0; debounce counters = 0.
  - FSM = STOP.
  - run_stop = 0, clear = 0, lap_hold = 0.
- Synchronizer, per button: s1 <= raw; s2 <= s1.
- Debouncer, per button; counter width clog2(DEB_CYCLES+1):
  - s2 == deb: cnt <= 0.
  - s2 != deb and cnt == DEB_CYCLES-1: deb <= s2, cnt <= 0.
  - Otherwise: cnt <= cnt+1.
  - Any return of s2 to deb before acceptance restarts the count; glitches shorter than DEB_CYCLES are fully rejected.
- Edge detect: deb_d <= deb; pulse = deb & ~deb_d (combinational, high exactly one cycle per accepted press). Release produces no pulse.
- Latency: if raw is first sampled high at edge 1 and held, deb rises at edge DEB_CYCLES+2, pulse is high in the following cycle, and the FSM acts at edge DEB_CYCLES+3.
- FSM states: STOP, RUN, CLEAR. Outputs are Moore-decoded from the state register: run_stop = (state==RUN), clear = (state==CLEAR).
- STOP:
  - clear pulse -> CLEAR.
  - else run pulse -> RUN.
  - Simultaneous run+clear pulses: clear wins, run is dropped.
- RUN:
  - run pulse -> STOP.
  - clear pulse ignored (no clearing while running).
- CLEAR: unconditionally -> STOP next edge, so clear is exactly 1 cycle. Pulses arriving while in CLEAR are dropped.
- Held buttons never retrigger; a new press requires a debounced release first.
- Reset mid-press: debouncer restarts from 0. A button still held after reset is accepted as a new press after DEB_CYCLES+3 edges.

Optional Feature:
- Macro: STOPWATCH_CU_LAP_EN.
- Defined:
  - btn_lap passes through its own sync/debounce/edge path.
  - A lap pulse in RUN or STOP toggles lap_hold.
  - Entering CLEAR forces lap_hold <= 0 on the same edge.
  - A lap pulse coincident with a transition into CLEAR is dropped (clear has priority).
  - lap_hold does not affect run_stop.
- Undefined: lap sync/debounce logic is not instantiated, btn_lap is ignored, and lap_hold is tied to constant 0. Ports remain for pin compatibility.

Test Plan (DEB_CYCLES=4 in sim):
- Reset, then btn_run held high from edge 1 -> run_stop rises after edge 7, stays 1 while held; clear = 0 throughout.
- From RUN, second clean btn_run press (release >= 8 cycles, press held >= 8 cycles) -> run_stop = 0 exactly 7 edges after the press; no extra toggle on release.
- btn_run glitch high for 3 cycles, low, then high 2 cycles -> run_stop stays 0, debounce counter returns to 0.
- In STOP, btn_run and btn_clear rise the same cycle and are held -> clear = 1 for exactly 1 cycle, run_stop stays 0, FSM back in STOP.
- In RUN, btn_clear pressed -> clear stays 0, run_stop stays 1. Then rst asserted 1 cycle while btn_run is held -> run_stop = 0 next edge, then 1 again 7 edges after rst deasserts.
- STOPWATCH_CU_LAP_EN defined:
  - In RUN, press btn_lap -> lap_hold = 1, run_stop still 1.
  - Press btn_lap again -> lap_hold = 0.
  - Set lap_hold = 1, stop, press clear -> lap_hold = 0 on the same edge clear rises.
  - Macro undefined -> lap_hold is always 0.

Source files
------------

// File: rtl/stopwatch_cu.sv
// Stopwatch control unit: synchronizes, debounces and edge-detects the push buttons and
// drives a STOP/RUN/CLEAR Moore FSM. The lap feature is enabled by defining STOPWATCH_CU_LAP_EN.

module stopwatch_cu_btn #(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_pulse
);
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          r_s1;
    logic          r_s2;
    logic          r_deb;
    logic          r_deb_d;
    logic [CW-1:0] r_cnt;

    // Any return of the synchronized level to the accepted level restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_deb   <= 1'b0;
            r_deb_d <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_s1    <= i_raw;
            r_s2    <= r_s1;
            r_deb_d <= r_deb;
            if (r_s2 == r_deb) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEB_CYCLES - 1)) begin
                r_deb <= r_s2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_pulse = r_deb & ~r_deb_d;
endmodule

module stopwatch_cu #(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_run,
    input  logic btn_clear,
    input  logic btn_lap,
    output logic run_stop,
    output logic clear,
    output logic lap_hold
);
    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    state_t r_state;
    logic   r_run_stop;
    logic   r_clear;
    logic   w_run_pulse;
    logic   w_clear_pulse;

    stopwatch_cu_btn #(.DEB_CYCLES(DEB_CYCLES)) u_run (
        .clk     (clk),
        .rst     (rst),
        .i_raw   (btn_run),
        .o_pulse (w_run_pulse)
    );

    stopwatch_cu_btn #(.DEB_CYCLES(DEB_CYCLES)) u_clear (
        .clk     (clk),
        .rst     (rst),
        .i_raw   (btn_clear),
        .o_pulse (w_clear_pulse)
    );

`ifdef STOPWATCH_CU_LAP_EN
    logic r_lap_hold;
    logic w_lap_pulse;

    stopwatch_cu_btn #(.DEB_CYCLES(DEB_CYCLES)) u_lap (
        .clk     (clk),
        .rst     (rst),
        .i_raw   (btn_lap),
        .o_pulse (w_lap_pulse)
    );

    assign lap_hold = r_lap_hold;
`else
    // Lap path absent: the pin is kept but contributes nothing.
    assign lap_hold = btn_lap & 1'b0;
`endif

    // Outputs are registered alongside the state so they always equal its decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_STOP;
            r_run_stop <= 1'b0;
            r_clear    <= 1'b0;
`ifdef STOPWATCH_CU_LAP_EN
            r_lap_hold <= 1'b0;
`endif
        end else begin
            r_clear <= 1'b0;
            case (r_state)
                ST_STOP: begin
                    if (w_clear_pulse) begin
                        r_state    <= ST_CLEAR;
                        r_clear    <= 1'b1;
                        r_run_stop <= 1'b0;
`ifdef STOPWATCH_CU_LAP_EN
                        r_lap_hold <= 1'b0;
`endif
                    end else begin
                        if (w_run_pulse) begin
                            r_state    <= ST_RUN;
                            r_run_stop <= 1'b1;
                        end
`ifdef STOPWATCH_CU_LAP_EN
                        if (w_lap_pulse) r_lap_hold <= ~r_lap_hold;
`endif
                    end
                end
                ST_RUN: begin
                    if (w_run_pulse) begin
                        r_state    <= ST_STOP;
                        r_run_stop <= 1'b0;
                    end
`ifdef STOPWATCH_CU_LAP_EN
                    if (w_lap_pulse) r_lap_hold <= ~r_lap_hold;
`endif
                end
                ST_CLEAR: begin
                    r_state    <= ST_STOP;
                    r_run_stop <= 1'b0;
                end
                default: begin
                    r_state    <= ST_STOP;
                    r_run_stop <= 1'b0;
                end
            endcase
        end
    end

    assign run_stop = r_run_stop;
    assign clear    = r_clear;
endmodule

// File: tb/tb_stopwatch_cu.sv
// Directed bench for stopwatch_cu with DEB_CYCLES=4; lap checks follow STOPWATCH_CU_LAP_EN.

module tb_stopwatch_cu;
    logic clk = 1'b0;
    logic rst;
    logic btn_run;
    logic btn_clear;
    logic btn_lap;
    logic run_stop;
    logic clear;
    logic lap_hold;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    stopwatch_cu #(.DEB_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_run   (btn_run),
        .btn_clear (btn_clear),
        .btn_lap   (btn_lap),
        .run_stop  (run_stop),
        .clear     (clear),
        .lap_hold  (lap_hold)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n edges checking the three outputs stay at the given levels.
    task automatic hold_chk(input string tag, input int n, input logic rs, input logic cl, input logic lh);
        for (int i = 0; i < n; i++) begin
            tick();
            chk({tag, "_run_stop"}, 8'(run_stop), 8'(rs));
            chk({tag, "_clear"}, 8'(clear), 8'(cl));
            chk({tag, "_lap_hold"}, 8'(lap_hold), 8'(lh));
        end
    endtask

    initial begin
        rst = 1'b1; btn_run = 1'b0; btn_clear = 1'b0; btn_lap = 1'b0;
        tick(); tick();
        chk("reset_run_stop", 8'(run_stop), 8'd0);
        chk("reset_clear", 8'(clear), 8'd0);
        chk("reset_lap_hold", 8'(lap_hold), 8'd0);

        // First press: raw sampled at edge 1, FSM acts at edge 7.
        rst = 1'b0; btn_run = 1'b1;
        hold_chk("press1_wait", 6, 1'b0, 1'b0, 1'b0);
        hold_chk("press1_run", 1, 1'b1, 1'b0, 1'b0);
        hold_chk("press1_held", 10, 1'b1, 1'b0, 1'b0);

        // Release, then a second press stops the watch at its 7th edge.
        btn_run = 1'b0;
        hold_chk("release1", 10, 1'b1, 1'b0, 1'b0);
        btn_run = 1'b1;
        hold_chk("press2_wait", 6, 1'b1, 1'b0, 1'b0);
        hold_chk("press2_stop", 1, 1'b0, 1'b0, 1'b0);
        hold_chk("press2_held", 10, 1'b0, 1'b0, 1'b0);
        btn_run = 1'b0;
        hold_chk("release2", 10, 1'b0, 1'b0, 1'b0);

        // Glitches of 3 and 2 cycles are rejected.
        btn_run = 1'b1;
        hold_chk("glitch_a", 3, 1'b0, 1'b0, 1'b0);
        btn_run = 1'b0;
        hold_chk("glitch_gap", 3, 1'b0, 1'b0, 1'b0);
        btn_run = 1'b1;
        hold_chk("glitch_b", 2, 1'b0, 1'b0, 1'b0);
        btn_run = 1'b0;
        hold_chk("glitch_tail", 8, 1'b0, 1'b0, 1'b0);
        chk("glitch_cnt_zero", 8'(dut.u_run.r_cnt), 8'd0);
        chk("glitch_deb_low", 8'(dut.u_run.r_deb), 8'd0);

        // Simultaneous run+clear in STOP: clear wins for exactly one cycle.
        btn_run = 1'b1; btn_clear = 1'b1;
        hold_chk("both_wait", 6, 1'b0, 1'b0, 1'b0);
        hold_chk("both_clear", 1, 1'b0, 1'b1, 1'b0);
        hold_chk("both_after", 8, 1'b0, 1'b0, 1'b0);
        btn_run = 1'b0; btn_clear = 1'b0;
        hold_chk("both_release", 10, 1'b0, 1'b0, 1'b0);

        // Enter RUN and keep btn_run held; clear is ignored while running.
        btn_run = 1'b1;
        hold_chk("run3_wait", 6, 1'b0, 1'b0, 1'b0);
        hold_chk("run3_run", 1, 1'b1, 1'b0, 1'b0);
        btn_clear = 1'b1;
        hold_chk("clr_in_run", 10, 1'b1, 1'b0, 1'b0);
        btn_clear = 1'b0;
        hold_chk("clr_release", 10, 1'b1, 1'b0, 1'b0);

        // One-cycle reset with btn_run still held: re-accepted 7 edges later.
        rst = 1'b1;
        hold_chk("mid_reset", 1, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        hold_chk("post_rst_wait", 6, 1'b0, 1'b0, 1'b0);
        hold_chk("post_rst_run", 1, 1'b1, 1'b0, 1'b0);
        hold_chk("post_rst_held", 4, 1'b1, 1'b0, 1'b0);

`ifdef STOPWATCH_CU_LAP_EN
        btn_lap = 1'b1;
        hold_chk("lap1_wait", 6, 1'b1, 1'b0, 1'b0);
        hold_chk("lap1_set", 1, 1'b1, 1'b0, 1'b1);
        btn_lap = 1'b0;
        hold_chk("lap1_rel", 10, 1'b1, 1'b0, 1'b1);
        btn_lap = 1'b1;
        hold_chk("lap2_wait", 6, 1'b1, 1'b0, 1'b1);
        hold_chk("lap2_clr", 1, 1'b1, 1'b0, 1'b0);
        btn_lap = 1'b0;
        hold_chk("lap2_rel", 10, 1'b1, 1'b0, 1'b0);
        btn_lap = 1'b1;
        hold_chk("lap3_wait", 6, 1'b1, 1'b0, 1'b0);
        hold_chk("lap3_set", 1, 1'b1, 1'b0, 1'b1);
        btn_lap = 1'b0; btn_run = 1'b0;
        hold_chk("lap3_rel", 10, 1'b1, 1'b0, 1'b1);
        btn_run = 1'b1;
        hold_chk("stop_wait", 6, 1'b1, 1'b0, 1'b1);
        hold_chk("stop_done", 1, 1'b0, 1'b0, 1'b1);
        btn_run = 1'b0;
        hold_chk("stop_rel", 10, 1'b0, 1'b0, 1'b1);
        btn_clear = 1'b1;
        hold_chk("lapclr_wait", 6, 1'b0, 1'b0, 1'b1);
        hold_chk("lapclr_edge", 1, 1'b0, 1'b1, 1'b0);
        hold_chk("lapclr_after", 4, 1'b0, 1'b0, 1'b0);
        btn_clear = 1'b0;
        hold_chk("lapclr_rel", 8, 1'b0, 1'b0, 1'b0);
`else
        // Without the lap feature btn_lap has no effect at all.
        btn_lap = 1'b1;
        hold_chk("nolap_press", 12, 1'b1, 1'b0, 1'b0);
        btn_lap = 1'b0;
        hold_chk("nolap_rel", 10, 1'b1, 1'b0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
